// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch front-end.
package fetch_pkg;

    localparam int unsigned PC_W_DEF    = 4;
    localparam int unsigned INSTR_W_DEF = 16;
    localparam int unsigned DEPTH_DEF   = 4;

    // Queue pointer width for the default depth.
    localparam int unsigned QPTR_W = $clog2(DEPTH_DEF);

    // One buffered fetch result: the address it came from and the instruction word.
    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries. Flush dominates push and pop.
// Storage is reset so the head reads as zero while empty after reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned Depth   = DEPTH_DEF,
    parameter int unsigned PtrW    = QPTR_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [PtrW:0] count_o,
    output logic          empty_o,
    output entry_t        head_o
);

    logic [PtrW-1:0] wr_q, wr_d;
    logic [PtrW-1:0] rd_q, rd_d;
    logic [PtrW:0]   count_q, count_d;
    entry_t          mem_q [Depth];

    // Pointer and occupancy next-state; pointers wrap naturally at Depth.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
            if (push_i && !pop_i) begin
                count_d = count_q + 1'b1;
            end else if (!push_i && pop_i) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entry storage; a flushed push is discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the PC, issues one read per cycle to a synchronous
// instruction memory, buffers returns in a prefetch queue and supports redirects.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    input  logic               out_ready
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW+1:0] DepthW = DEPTH[PtrW+1:0];

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic            drop_q, drop_d;

    logic [PtrW:0]   q_count;
    logic            q_empty;
    entry_t          q_head;
    entry_t          push_data;
    logic            push;
    logic            pop;
    logic [PtrW+1:0] occupancy;
    logic            credit;
    logic            issue;

    // Queue slots already claimed: stored entries plus the one read in flight.
    assign occupancy = {1'b0, q_count} + {{(PtrW + 1){1'b0}}, inflight_q};
    assign credit    = (occupancy < DepthW);
    assign issue     = rst_n & fetch_en & ~redirect_valid & credit;

    assign imem_req  = issue;
    assign imem_addr = pc_q;

    // A response is kept only if it belongs to a live request and no redirect is in progress.
    assign push      = imem_rvalid & inflight_q & ~drop_q & ~redirect_valid;
    assign push_data = '{pc: req_pc_q, instr: imem_rdata};

    assign out_valid = ~q_empty & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign out_pc    = q_head.pc;
    assign out_instr = q_head.instr;

    // PC, in-flight tracking and stale-response drop next-state.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            // Any response still owed after this cycle must be discarded.
            drop_d     = (inflight_q | drop_q) & ~imem_rvalid;
        end else begin
            if (imem_rvalid) begin
                if (drop_q) begin
                    drop_d = 1'b0;
                end else if (inflight_q) begin
                    inflight_d = 1'b0;
                end
            end
            if (issue) begin
                pc_d       = pc_q + 1'b1;
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .entry_t (entry_t),
        .Depth   (DEPTH),
        .PtrW    (PtrW)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (q_count),
        .empty_o     (q_empty),
        .head_o      (q_head)
    );

endmodule
